// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: hazard inputs from ID/EX/MEM/WB
// and the register enable/flush/forwarding controls and counters going back.
interface hazard_ctrl_if #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH           = 32
);
    logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
    logic                           mem_read_EX, branch_taken_EX;
    logic                           reg_write_MEM, reg_write_WB;
    logic                           mem_op_MEM, dmem_ready;

    logic                           dmem_req;
    logic                           pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic                           if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [1:0]                     fwd_a_EX, fwd_b_EX;
    logic [CNT_WIDTH-1:0]           stall_cycles, flush_count;
    logic                           mem_timeout;
    logic                           mem_wait_state;

    modport master (
        output rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB,
               mem_read_EX, branch_taken_EX, reg_write_MEM, reg_write_WB,
               mem_op_MEM, dmem_ready,
        input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a_EX, fwd_b_EX,
               stall_cycles, flush_count, mem_timeout, mem_wait_state
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB,
               mem_read_EX, branch_taken_EX, reg_write_MEM, reg_write_WB,
               mem_op_MEM, dmem_ready,
        output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a_EX, fwd_b_EX,
               stall_cycles, flush_count, mem_timeout, mem_wait_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the 5-stage core: freeze/redirect/load-use decode,
// EX forwarding selects, memory-wait FSM, saturating perf counters and timeout flag.
module hazard_ctrl #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH           = 32,
    parameter int MAX_WAIT            = 16
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t               state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
    logic                 timeout_q;
    logic                 mem_busy, load_use;

    assign mem_busy = bus.mem_op_MEM & ~bus.dmem_ready;
    assign load_use = bus.mem_read_EX & (bus.rd_EX != '0) &
                      ((bus.rd_EX == bus.rs1_ID) | (bus.rd_EX == bus.rs2_ID));

    assign bus.dmem_req       = bus.mem_op_MEM;
    assign bus.mem_wait_state = (state == MEM_WAIT);
    assign bus.stall_cycles   = stall_cnt;
    assign bus.flush_count    = flush_cnt;
    assign bus.mem_timeout    = timeout_q;

    // Freeze outranks everything: EX/ID contents are held, so a pending
    // redirect or load-use stall simply re-decodes once memory releases.
    always_comb begin
        bus.pc_en         = 1'b1;
        bus.if_id_en      = 1'b1;
        bus.id_ex_en      = 1'b1;
        bus.ex_mem_en     = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_flush   = 1'b0;
        bus.mem_wb_bubble = 1'b0;
        if (mem_busy) begin
            bus.pc_en         = 1'b0;
            bus.if_id_en      = 1'b0;
            bus.id_ex_en      = 1'b0;
            bus.ex_mem_en     = 1'b0;
            bus.mem_wb_bubble = 1'b1;
        end else if (bus.branch_taken_EX) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [REGISTER_ADDR_WIDTH-1:0] rs,
        input logic [REGISTER_ADDR_WIDTH-1:0] rd_mem,
        input logic                           wr_mem,
        input logic [REGISTER_ADDR_WIDTH-1:0] rd_wb,
        input logic                           wr_wb
    );
        if (wr_mem && rd_mem != '0 && rd_mem == rs)
            return 2'b10;
        else if (wr_wb && rd_wb != '0 && rd_wb == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign bus.fwd_a_EX = fwd_sel(bus.rs1_EX, bus.rd_MEM, bus.reg_write_MEM, bus.rd_WB, bus.reg_write_WB);
    assign bus.fwd_b_EX = fwd_sel(bus.rs2_EX, bus.rd_MEM, bus.reg_write_MEM, bus.rd_WB, bus.reg_write_WB);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN:      if (mem_busy) state <= MEM_WAIT;
                MEM_WAIT: if (bus.dmem_ready) state <= RUN;
                default:  state <= RUN;
            endcase

            // In RUN the run length is always zero, so the first busy edge seeds 1.
            if (!mem_busy)
                wait_cnt <= '0;
            else if (state == RUN)
                wait_cnt <= WAIT_W'(1);
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (mem_busy && wait_cnt == WAIT_W'(MAX_WAIT - 1))
                timeout_q <= 1'b1;

            if (!bus.pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (bus.if_id_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Drives the enable, flush and bubble controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. Resolves load-use hazards, taken-branch redirects and data-memory wait states, generates the EX-stage forwarding selects, and keeps saturating stall and flush performance counters plus a sticky memory-timeout flag.

## Interface
- REGISTER_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, performance counter width
- MAX_WAIT, 16, consecutive memory-busy cycles before the timeout flag sets (≥2)
- cpu_clk  in  1  clock; all state updates on the rising edge
- cpu_rst_n  in  1  asynchronous, active-low reset
- rs1_ID, rs2_ID  in  REGISTER_ADDR_WIDTH  source registers of the instruction in ID
- rs1_EX, rs2_EX  in  REGISTER_ADDR_WIDTH  source registers of the instruction in EX
- rd_EX  in  REGISTER_ADDR_WIDTH  destination of the instruction in EX
- mem_read_EX  in  1  instruction in EX is a load
- branch_taken_EX  in  1  EX resolved a taken branch or jump
- rd_MEM, reg_write_MEM  in  5/1  destination and write enable in MEM
- rd_WB, reg_write_WB  in  5/1  destination and write enable in WB
- mem_op_MEM  in  1  instruction in MEM is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data-memory request
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  register enables (1 = advance)
- if_id_flush, id_ex_flush  out  1  load a bubble (all zeros)
- mem_wb_bubble  out  1  MEM_WB captures a bubble: reg_write and INST are forced to 0
- fwd_a_EX, fwd_b_EX  out  2  00 = register file, 01 = WB result, 10 = MEM alu_res
- stall_cycles, flush_count  out  CNT_WIDTH  performance counters
- mem_timeout  out  1  sticky error flag

## Operation
- mem_busy = mem_op_MEM & ~dmem_ready. dmem_req = mem_op_MEM.
- load_use = mem_read_EX & (rd_EX≠0) & (rd_EX==rs1_ID | rd_EX==rs2_ID).
- Controls are decoded combinationally, in strict priority order:
  1. mem_busy (freeze): all enables are 0, mem_wb_bubble=1, and all flushes are 0.
  2. branch_taken_EX: all enables are 1, if_id_flush=1, id_ex_flush=1.
  3. load_use: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1.
  4. Otherwise all enables are 1, and flushes and bubble are 0.
- A flush is never asserted with its register's enable low.
- Forwarding, evaluated per source operand:
  - Select 10 if reg_write_MEM & rd_MEM≠0 & rd_MEM==rs.
  - Else select 01 if reg_write_WB & rd_WB≠0 & rd_WB==rs.
  - Else select 00.
  - MEM wins over WB.
- FSM has two states, RUN and MEM_WAIT:
  - RUN → MEM_WAIT on an edge with mem_busy.
  - MEM_WAIT → RUN on an edge with dmem_ready.
  - MEM_WAIT holds otherwise.
- Both FSM states decode controls identically. The state is exposed for debug and gates wait_cnt.
- wait_cnt (internal, width $clog2(MAX_WAIT)+1) counts consecutive mem_busy cycles:
  - Increments, saturating, on each edge with mem_busy.
  - Clears to 0 on any edge without mem_busy.
- mem_timeout sets on the edge where mem_busy & wait_cnt==MAX_WAIT-1. It clears only by reset. Stalling continues regardless of the flag.
- stall_cycles: +1 on each edge with pc_en=0.
- flush_count: +1 on each edge with if_id_flush=1.
- Both counters saturate at all-ones.

## Timing
- Reset values:
  - state=RUN, wait_cnt=0, stall_cycles=0, flush_count=0, mem_timeout=0.
  - With inputs at 0, the decoded outputs are all enables 1, flushes 0, mem_wb_bubble 0, dmem_req 0, forwarding selects 00.
- Controls and forwarding have zero-cycle latency: combinational from the current inputs.
- Counters and the flag update one edge after the qualifying cycle.
- dmem_ready asserted in the first cycle of mem_op_MEM: no stall; the FSM stays in RUN.
- Freeze while branch_taken_EX or load_use is pending: the redirect or stall is suppressed and re-evaluated after release, because the EX and ID contents are held.
- Branch and load-use in the same cycle: the branch wins; the younger load-use instruction is flushed.
- Asynchronous reset mid-wait: the FSM returns to RUN immediately and all counters and the flag clear without a clock edge.

## Test plan
- Load-use: mem_read_EX=1, rd_EX=5, rs1_ID=5 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1 after the edge.
- rd_EX=0 with a matching rs1_ID=0 → no stall, all enables 1.
- Branch: branch_taken_EX=1 for 1 cycle → if_id_flush=id_ex_flush=1, enables 1; flush_count 0→1.
- Memory wait: mem_op_MEM=1, dmem_ready low for 3 cycles then high → 3 frozen cycles with mem_wb_bubble=1 and state MEM_WAIT; release in the ready cycle; state back to RUN; stall_cycles=3.
- Timeout (MAX_WAIT=16): dmem_ready held low 16 cycles → mem_timeout rises after the 16th edge; it stays 1 after ready; reset clears it asynchronously.
- Forwarding: rd_MEM=rd_WB=7, both writing, rs1_EX=7 → fwd_a_EX=10. Then reg_write_MEM=0 → 01. Then rd=0 → 00.
